imem_loader: RTL and testbench
==============================

IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 Parameter MAX_WORDS, default 256, meaning instruction memory capacity in 32-bit words (1 KB byte space, 10-bit byte address).
REQ-002 Parameter RELEASE_CYCLES, default 2, meaning cycles core_reset stays asserted after the last write, before the core runs.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 Reset  input  1  reset, synchronous, active-high.
REQ-005 start  input  1  one-cycle pulse requesting a (re)load; sampled only in IDLE, RUN and ERR.
REQ-006 prog_len  input  9  number of words to load; sampled on accepted start.
REQ-007 word_valid  input  1  source has a word on word_data.
REQ-008 word_data  input  32  instruction word from source.
REQ-009 word_ready  output  1  loader accepts a word this cycle.
REQ-010 WE_mem  output  1  instruction-memory write enable.
REQ-011 WD_mem  output  32  instruction-memory write data.
REQ-012 mem_addr  output  10  instruction-memory byte address for the write.
REQ-013 Write  output  1  core instruction/branch suppression (forces NOP fetch while high).
REQ-014 core_reset  output  1  holds core PC at 0 while high.
REQ-015 busy  output  1  high in LOAD and FLUSH.
REQ-016 done  output  1  high in RUN.
REQ-017 error  output  1  high in ERR.

Function
REQ-018 FSM states SHALL be IDLE, LOAD, FLUSH, RUN, ERR; all outputs registered or decoded from registered state only.
REQ-019 IDLE: Write=1, core_reset=1, word_ready=0; start with 1<=prog_len<=MAX_WORDS -> LOAD, word counter cleared, length latched.
REQ-020 start with prog_len==0 or prog_len>MAX_WORDS SHALL go to ERR, no memory write performed.
REQ-021 LOAD: Write=1, core_reset=1, word_ready=1 while fewer than latched length words accepted; transfer = word_valid && word_ready.
REQ-022 On transfer n (n from 0), the next cycle SHALL show WE_mem=1, WD_mem=word_data of that transfer, mem_addr=4*n; latency exactly 1 cycle, one write per transfer.
REQ-023 WE_mem SHALL be 0 in every cycle not following a transfer; word_valid low stalls without penalty, back-to-back transfers write on consecutive cycles.
REQ-024 word_ready SHALL drop in the cycle after the final transfer; state -> FLUSH on the cycle the final write is presented.
REQ-025 mem_addr SHALL not wrap: final address is 4*(len-1) <= 4*(MAX_WORDS-1) = 1020.
REQ-026 FLUSH: Write=1, core_reset=1 for exactly RELEASE_CYCLES cycles, then -> RUN.
REQ-027 RUN: Write=0, core_reset=0, done=1; remains until Reset or start.
REQ-028 start in RUN SHALL behave as in IDLE (valid length -> LOAD with Write=1, core_reset=1 from the next cycle; invalid -> ERR).
REQ-029 start during LOAD or FLUSH SHALL be ignored.
REQ-030 ERR: Write=1, core_reset=1, error=1; start with valid length -> LOAD, invalid -> stays ERR.

Reset
REQ-031 Reset high at a rising edge SHALL force IDLE, counters 0, WE_mem=0, WD_mem=0, mem_addr=0, word_ready=0, Write=1, core_reset=1, busy=0, done=0, error=0.
REQ-032 Reset mid-LOAD or mid-FLUSH SHALL abort without a further memory write; a pending registered write is discarded.
REQ-033 Reset has priority over start and transfers in the same cycle.

Verification
REQ-034 Reset, start with prog_len=3, words 0x00500093, 0x00100113, 0x002081B3 with valid always high -> WE_mem on 3 consecutive cycles at mem_addr 0,4,8 with those data, FLUSH 2 cycles, then done=1, Write=0, core_reset=0.
REQ-035 prog_len=4 with word_valid toggling 1,0,1,0,... -> exactly 4 writes at 0,4,8,12, no WE_mem in gap cycles, word_ready=0 after 4th transfer.
REQ-036 prog_len=0 and prog_len=257 -> error=1, no WE_mem, Write=1; then start with prog_len=1 -> single write at 0, done=1.
REQ-037 prog_len=256 -> last write at mem_addr 1020, no write at 0 after wrap, RUN reached.
REQ-038 Reset asserted after 2 of 5 transfers -> next cycle IDLE, WE_mem=0, core_reset=1; start pulse during FLUSH ignored.
REQ-039 In RUN, start with prog_len=2 -> Write=1 and core_reset=1 next cycle, 2 writes at 0,4, back to RUN.

Source files
------------

// File: rtl/imem_loader.sv
// Instruction-memory loader: streams a program into IMEM while holding
// the core in reset, then releases it after a short flush window.
module imem_loader #(
    parameter int MAX_WORDS      = 256,
    parameter int RELEASE_CYCLES = 2
) (
    input  logic        clk,
    input  logic        Reset,
    input  logic        start,
    input  logic [8:0]  prog_len,
    input  logic        word_valid,
    input  logic [31:0] word_data,
    output logic        word_ready,
    output logic        WE_mem,
    output logic [31:0] WD_mem,
    output logic [9:0]  mem_addr,
    output logic        Write,
    output logic        core_reset,
    output logic        busy,
    output logic        done,
    output logic        error
);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        FLUSH,
        RUN,
        ERR
    } state_t;

    localparam logic [9:0] LEN_MAX    = 10'(MAX_WORDS);
    localparam logic [7:0] FLUSH_LAST = 8'(RELEASE_CYCLES - 1);

    state_t      state;
    state_t      state_nx;
    logic [8:0]  cnt;
    logic [8:0]  len;
    logic [7:0]  fcnt;
    logic        we_q;
    logic [31:0] wd_q;
    logic [9:0]  addr_q;

    logic        can_start;
    logic        len_ok;
    logic        accept;
    logic        xfer;
    logic        last;

    assign can_start = (state == IDLE) || (state == RUN) || (state == ERR);
    assign len_ok    = (prog_len != 9'd0) && ({1'b0, prog_len} <= LEN_MAX);
    assign accept    = start && can_start && len_ok;

    assign word_ready = (state == LOAD) && (cnt < len);
    assign xfer       = word_valid && word_ready;
    assign last       = xfer && (cnt == len - 9'd1);

    always_ff @(posedge clk) begin
        if (Reset) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE, RUN, ERR: begin
                if (start) begin
                    state_nx = len_ok ? LOAD : ERR;
                end
            end
            LOAD: begin
                if (last) begin
                    state_nx = FLUSH;
                end
            end
            FLUSH: begin
                if (fcnt == FLUSH_LAST) begin
                    state_nx = RUN;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // The write port is a one-cycle delayed copy of each accepted word.
    always_ff @(posedge clk) begin
        if (Reset) begin
            cnt    <= '0;
            len    <= '0;
            fcnt   <= '0;
            we_q   <= 1'b0;
            wd_q   <= '0;
            addr_q <= '0;
        end else begin
            we_q <= xfer;
            if (xfer) begin
                wd_q   <= word_data;
                addr_q <= {cnt[7:0], 2'b00};
                cnt    <= cnt + 9'd1;
            end
            if (accept) begin
                cnt <= '0;
                len <= prog_len;
            end
            fcnt <= (state == FLUSH) ? fcnt + 8'd1 : 8'd0;
        end
    end

    assign WE_mem     = we_q;
    assign WD_mem     = wd_q;
    assign mem_addr   = addr_q;
    assign Write      = (state != RUN);
    assign core_reset = (state != RUN);
    assign busy       = (state == LOAD) || (state == FLUSH);
    assign done       = (state == RUN);
    assign error      = (state == ERR);

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: table of load scenarios plus
// hand-written reset-abort and start-during-flush sequences.
module tb_imem_loader;

    logic        clk;
    logic        Reset;
    logic        start;
    logic [8:0]  prog_len;
    logic        word_valid;
    logic [31:0] word_data;
    logic        word_ready;
    logic        WE_mem;
    logic [31:0] WD_mem;
    logic [9:0]  mem_addr;
    logic        Write;
    logic        core_reset;
    logic        busy;
    logic        done;
    logic        error;

    imem_loader #(
        .MAX_WORDS(256),
        .RELEASE_CYCLES(2)
    ) dut (
        .clk(clk),
        .Reset(Reset),
        .start(start),
        .prog_len(prog_len),
        .word_valid(word_valid),
        .word_data(word_data),
        .word_ready(word_ready),
        .WE_mem(WE_mem),
        .WD_mem(WD_mem),
        .mem_addr(mem_addr),
        .Write(Write),
        .core_reset(core_reset),
        .busy(busy),
        .done(done),
        .error(error)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic [8:0]  plen;
        int          vmode;
        logic [31:0] seed;
        bit          err;
    } vec_t;

    int          n_vec = 0;
    int          n_err = 0;
    logic [31:0] wmem [256];

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic fill(input logic [31:0] seed);
        for (int i = 0; i < 256; i++) begin
            wmem[i] = seed ^ (32'(i) * 32'h9E3779B1);
        end
    endtask

    // Drive one load of plen words from wmem; vmode 1 toggles word_valid.
    task automatic run_load(input logic [8:0] plen, input int vmode,
                            input bit exp_err);
        int          n;
        int          cyc;
        bit          pend;
        bit          tog;
        logic [31:0] pd;
        logic [9:0]  pa;
        @(negedge clk);
        start = 1'b1;
        prog_len = plen;
        word_valid = 1'b0;
        @(negedge clk);
        start = 1'b0;
        if (exp_err) begin
            for (int k = 0; k < 3; k++) begin
                chk("err_flag", error, 1);
                chk("err_write", Write, 1);
                chk("err_core_reset", core_reset, 1);
                chk("err_we", WE_mem, 0);
                chk("err_busy", busy, 0);
                chk("err_ready", word_ready, 0);
                @(negedge clk);
            end
            return;
        end
        n = 0;
        cyc = 0;
        pend = 1'b0;
        tog = 1'b0;
        pd = '0;
        pa = '0;
        while ((n < int'(plen) || pend) && cyc < 1200) begin
            chk("we", WE_mem, 32'(pend));
            if (pend) begin
                chk("wd", WD_mem, pd);
                chk("addr", mem_addr, 32'(pa));
            end
            chk("ready", word_ready, 32'(n < int'(plen)));
            chk("busy", busy, 1);
            chk("load_write", Write, 1);
            chk("load_core_reset", core_reset, 1);
            word_valid = (vmode == 0) ? 1'b1 : ~tog;
            tog = ~tog;
            word_data = (n < 256) ? wmem[n] : 32'hDEADBEEF;
            pend = word_valid && (n < int'(plen));
            pd = word_data;
            pa = 10'(n * 4);
            if (pend) n++;
            @(negedge clk);
            cyc++;
        end
        chk("load_timeout", 32'(cyc < 1200), 1);
        word_valid = 1'b0;
        chk("flush2_busy", busy, 1);
        chk("flush2_done", done, 0);
        chk("flush2_we", WE_mem, 0);
        @(negedge clk);
        chk("run_done", done, 1);
        chk("run_write", Write, 0);
        chk("run_core_reset", core_reset, 0);
        chk("run_busy", busy, 0);
        chk("run_we", WE_mem, 0);
    endtask

    vec_t vecs [6];

    initial begin
        vecs[0] = '{plen: 9'd4,   vmode: 1, seed: 32'h1234_5678, err: 1'b0};
        vecs[1] = '{plen: 9'd0,   vmode: 0, seed: 32'h0,         err: 1'b1};
        vecs[2] = '{plen: 9'd257, vmode: 0, seed: 32'h0,         err: 1'b1};
        vecs[3] = '{plen: 9'd1,   vmode: 0, seed: 32'hCAFE_F00D, err: 1'b0};
        vecs[4] = '{plen: 9'd256, vmode: 0, seed: 32'hA5A5_0F0F, err: 1'b0};
        vecs[5] = '{plen: 9'd2,   vmode: 0, seed: 32'h0BAD_C0DE, err: 1'b0};

        Reset = 1'b1;
        start = 1'b0;
        prog_len = '0;
        word_valid = 1'b0;
        word_data = '0;
        repeat (2) @(negedge clk);
        chk("rst_we", WE_mem, 0);
        chk("rst_wd", WD_mem, 0);
        chk("rst_addr", mem_addr, 0);
        chk("rst_ready", word_ready, 0);
        chk("rst_write", Write, 1);
        chk("rst_core_reset", core_reset, 1);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_error", error, 0);
        Reset = 1'b0;

        wmem[0] = 32'h0050_0093;
        wmem[1] = 32'h0010_0113;
        wmem[2] = 32'h0020_81B3;
        run_load(9'd3, 0, 1'b0);

        for (int v = 0; v < 6; v++) begin
            fill(vecs[v].seed);
            run_load(vecs[v].plen, vecs[v].vmode, vecs[v].err);
        end

        // Reset after two of five transfers aborts the load.
        @(negedge clk);
        start = 1'b1;
        prog_len = 9'd5;
        @(negedge clk);
        start = 1'b0;
        word_valid = 1'b1;
        word_data = 32'hA000_0000;
        @(negedge clk);
        chk("abort_w0_we", WE_mem, 1);
        chk("abort_w0_addr", mem_addr, 0);
        word_data = 32'hA000_0001;
        @(negedge clk);
        chk("abort_w1_we", WE_mem, 1);
        chk("abort_w1_addr", mem_addr, 4);
        chk("abort_w1_wd", WD_mem, 32'hA000_0001);
        Reset = 1'b1;
        word_data = 32'hA000_0002;
        @(negedge clk);
        chk("abort_we", WE_mem, 0);
        chk("abort_core_reset", core_reset, 1);
        chk("abort_busy", busy, 0);
        chk("abort_ready", word_ready, 0);
        chk("abort_addr", mem_addr, 0);
        Reset = 1'b0;
        word_valid = 1'b0;
        @(negedge clk);
        chk("abort_idle_we", WE_mem, 0);
        chk("abort_idle_done", done, 0);

        // Start pulse during FLUSH must be ignored.
        start = 1'b1;
        prog_len = 9'd1;
        @(negedge clk);
        start = 1'b0;
        word_valid = 1'b1;
        word_data = 32'h1357_9BDF;
        @(negedge clk);
        word_valid = 1'b0;
        chk("fl_we", WE_mem, 1);
        chk("fl_wd", WD_mem, 32'h1357_9BDF);
        chk("fl_busy", busy, 1);
        start = 1'b1;
        prog_len = 9'd3;
        @(negedge clk);
        start = 1'b0;
        chk("fl2_busy", busy, 1);
        chk("fl2_ready", word_ready, 0);
        chk("fl2_we", WE_mem, 0);
        @(negedge clk);
        chk("fl_run_done", done, 1);
        chk("fl_run_ready", word_ready, 0);
        chk("fl_run_write", Write, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
